// File: rtl/rtc_pkg.sv
// rtc_pkg: shared encoding type, field limits and BCD helpers for runtime_clock
package rtc_pkg;

    typedef enum logic {ENC_BIN = 1'b0, ENC_BCD = 1'b1} enc_e;

    localparam int LIM_59 = 59;

    function automatic logic [63:0] to_enc(longint unsigned v, enc_e enc);
        logic [63:0] r;
        r = v;
        if (enc == ENC_BCD) begin
            for (int i = 0; i < 16; i++) begin
                r[4*i+:4] = 4'(v % 64'd10);
                v = v / 64'd10;
            end
        end
        return r;
    endfunction

    // Largest legal value of a field, already in the field's encoding; modulus 0 means full capacity.
    function automatic logic [63:0] field_max(int w, enc_e enc, longint unsigned modulus);
        longint unsigned cap;
        cap = 64'd1;
        for (int i = 0; i < ((enc == ENC_BCD) ? w / 4 : w); i++)
            cap = cap * ((enc == ENC_BCD) ? 64'd10 : 64'd2);
        return to_enc(((modulus == 64'd0) ? cap : modulus) - 64'd1, enc);
    endfunction

    function automatic logic bcd_valid(logic [63:0] v, int w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < w / 4; i++)
            if (v[4*i+:4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/rtc_field.sv
// rtc_field: one time-field modulus counter with binary/BCD increment, carry, load and clear
module rtc_field
    import rtc_pkg::*;
#(
    parameter int W = 12,
    parameter enc_e ENC = ENC_BIN,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] val,
    output logic         carry
);

    logic [W-1:0] val_q, val_d, inc_v;
    logic         c;

    always_comb begin
        inc_v = val_q + 1'b1;
        c = 1'b1;
        if (ENC == ENC_BCD) begin
            inc_v = val_q;
            for (int i = 0; i < W / 4; i++) begin
                if (c) begin
                    c = val_q[4*i+:4] == 4'd9;
                    inc_v[4*i+:4] = c ? 4'd0 : val_q[4*i+:4] + 4'd1;
                end
            end
        end
        carry = inc && val_q == MAX;
        val_d = clr ? '0 : load ? load_val : !inc ? val_q : carry ? '0 : inc_v;
    end

    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/runtime_clock.sv
// runtime_clock: elapsed hh:mm:ss counter with one-second prescaler,
// binary/BCD fields, validated preset and tick/rollover/error strobes
module runtime_clock
    import rtc_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int W         = 12,
    parameter bit BCD       = 1'b0,
    parameter int HR_MODULO = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] load_hr,
    input  logic [W-1:0] load_min,
    input  logic [W-1:0] load_sec,
    output logic [W-1:0] hr,
    output logic [W-1:0] min,
    output logic [W-1:0] sec,
    output logic         tick_sec,
    output logic         rollover,
    output logic         load_err
);

    localparam enc_e          ENC      = BCD ? ENC_BCD : ENC_BIN;
    localparam int            PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_TERM = PW'(CLK_HZ - 1);
    localparam logic [W-1:0]  MS_MAX   = W'(field_max(W, ENC, 64'(LIM_59 + 1)));
    localparam logic [W-1:0]  HR_MAX   = W'(field_max(W, ENC, 64'(HR_MODULO)));

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d, roll_q, roll_d, err_q, err_d;
    logic          valid, accept, term, adv, c_sec, c_min, c_hr;

    always_comb begin
        valid = load_sec <= MS_MAX && load_min <= MS_MAX && load_hr <= HR_MAX &&
                (ENC == ENC_BIN || (bcd_valid(64'(load_sec), W) &&
                 bcd_valid(64'(load_min), W) && bcd_valid(64'(load_hr), W)));
        accept = load && valid && !clr;
        term = pre_q == PRE_TERM;
        // An accepted preset swallows a coinciding tick; a rejected one does not.
        adv = run && term && !accept && !clr;
        pre_d = (clr || accept) ? '0 : !run ? pre_q : term ? '0 : pre_q + 1'b1;
        tick_d = adv;
        roll_d = c_hr;
        err_d = load && !valid && !clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            roll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            roll_q <= roll_d;
            err_q  <= err_d;
        end
    end

    rtc_field #(.W(W), .ENC(ENC), .MAX(MS_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(clr), .load(accept), .inc(adv),
        .load_val(load_sec), .val(sec), .carry(c_sec)
    );

    rtc_field #(.W(W), .ENC(ENC), .MAX(MS_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(clr), .load(accept), .inc(c_sec),
        .load_val(load_min), .val(min), .carry(c_min)
    );

    rtc_field #(.W(W), .ENC(ENC), .MAX(HR_MAX)) u_hr (
        .clk(clk), .rst(rst), .clr(clr), .load(accept), .inc(c_min),
        .load_val(load_hr), .val(hr), .carry(c_hr)
    );

    assign tick_sec = tick_q;
    assign rollover = roll_q;
    assign load_err = err_q;

endmodule
